// File: rtl/data_mem_write_arbiter_pkg.sv
// data_mem_pkg: shared sizes and types for the 256x8 data memory write path.
package data_mem_pkg;
    localparam int NUM_CORES = 16;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [NUM_CORES-1:0] core_mask_t;
endpackage

// File: rtl/data_mem_write_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first eligible index at or after rr_ptr.
module rr_arbiter
    import data_mem_pkg::*;
#(
    parameter int NUM_PORTS = NUM_CORES,
    parameter int PW = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] i_eligible,
    input  logic [PW-1:0]        i_rr_ptr,
    output logic                 o_grant_valid,
    output logic [PW-1:0]        o_grant_idx
);
    logic [2*NUM_PORTS-1:0] w_rot;
    logic [PW:0]            w_sum;

    // Rotating a doubled copy puts rr_ptr at bit 0, so the lowest set bit is the winner.
    always_comb begin
        w_rot = {i_eligible, i_eligible} >> i_rr_ptr;
        w_sum = '0;
        o_grant_valid = 1'b0;
        o_grant_idx = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_sum = {1'b0, i_rr_ptr} + (PW+1)'(k);
                o_grant_valid = 1'b1;
                o_grant_idx = (w_sum >= (PW+1)'(NUM_PORTS)) ? PW'(w_sum - (PW+1)'(NUM_PORTS)) : PW'(w_sum);
            end
        end
    end
endmodule

// File: rtl/data_mem_write_arbiter.sv
// data_mem_write_arbiter: round-robin arbitration of core stores onto one registered memory write port.
// Define WR_ADDR_CONFLICT_EN to add the conflict / conflict_sticky same-address detection outputs.
module data_mem_write_arbiter #(
    parameter int NUM_PORTS = data_mem_pkg::NUM_CORES,
    parameter int ADDR_W = data_mem_pkg::ADDR_W,
    parameter int DATA_W = data_mem_pkg::DATA_W
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_PORTS-1:0]        wr_req,
    input  logic [NUM_PORTS*ADDR_W-1:0] wr_addr,
    input  logic [NUM_PORTS*DATA_W-1:0] wr_data,
    output logic [NUM_PORTS-1:0]        wr_ack,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_waddr,
    output logic [DATA_W-1:0]           mem_wdata,
    output logic                        busy
`ifdef WR_ADDR_CONFLICT_EN
    ,
    output logic                        conflict,
    output logic                        conflict_sticky
`endif
);
    localparam int PW = $clog2(NUM_PORTS);

    logic [NUM_PORTS-1:0] w_eligible;
    logic                 w_grant_valid;
    logic [PW-1:0]        w_grant_idx;
    logic [PW-1:0]        r_rr_ptr;
    logic [NUM_PORTS-1:0] r_wr_ack;
    logic                 r_mem_we;
    logic [ADDR_W-1:0]    r_mem_waddr;
    logic [DATA_W-1:0]    r_mem_wdata;

    // A port in its ack cycle is masked so a held req cannot win twice in a row.
    assign w_eligible = wr_req & ~r_wr_ack;
    assign busy = |w_eligible;
    assign wr_ack = r_wr_ack;
    assign mem_we = r_mem_we;
    assign mem_waddr = r_mem_waddr;
    assign mem_wdata = r_mem_wdata;

    rr_arbiter #(.NUM_PORTS(NUM_PORTS), .PW(PW)) u_rr_arbiter (
        .i_eligible(w_eligible),
        .i_rr_ptr(r_rr_ptr),
        .o_grant_valid(w_grant_valid),
        .o_grant_idx(w_grant_idx)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr_ptr <= '0;
            r_wr_ack <= '0;
            r_mem_we <= 1'b0;
            r_mem_waddr <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_mem_we <= w_grant_valid;
            r_wr_ack <= w_grant_valid ? NUM_PORTS'(1) << w_grant_idx : '0;
            if (w_grant_valid) begin
                r_rr_ptr <= (w_grant_idx == PW'(NUM_PORTS - 1)) ? '0 : w_grant_idx + 1'b1;
                r_mem_waddr <= wr_addr[int'(w_grant_idx)*ADDR_W +: ADDR_W];
                r_mem_wdata <= wr_data[int'(w_grant_idx)*DATA_W +: DATA_W];
            end
        end
    end

`ifdef WR_ADDR_CONFLICT_EN
    logic w_conflict;
    logic r_conflict;
    logic r_conflict_sticky;

    assign conflict = r_conflict;
    assign conflict_sticky = r_conflict_sticky;

    always_comb begin
        w_conflict = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++)
            for (int j = i + 1; j < NUM_PORTS; j++)
                if (w_eligible[i] && w_eligible[j] && wr_addr[i*ADDR_W +: ADDR_W] == wr_addr[j*ADDR_W +: ADDR_W])
                    w_conflict = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_conflict <= 1'b0;
            r_conflict_sticky <= 1'b0;
        end else begin
            r_conflict <= w_conflict;
            r_conflict_sticky <= r_conflict_sticky | w_conflict;
        end
    end
`endif
endmodule

// File: tb/tb_data_mem_write_arbiter.sv
// tb_data_mem_write_arbiter: directed and random stores checked against a round-robin reference model.
module tb_data_mem_write_arbiter;
    localparam int N = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] wr_req = '0;
    logic [N*8-1:0] wr_addr = '0;
    logic [N*8-1:0] wr_data = '0;
    logic [N-1:0] wr_ack;
    logic         mem_we;
    logic [7:0]   mem_waddr;
    logic [7:0]   mem_wdata;
    logic         busy;
`ifdef WR_ADDR_CONFLICT_EN
    logic         conflict;
    logic         conflict_sticky;
`endif

    int total = 0;
    int bad = 0;

    logic [N-1:0] m_ack;
    logic         m_we;
    logic [7:0]   m_addr;
    logic [7:0]   m_data;
    int           m_ptr;
    logic         m_conf;
    logic         m_sticky;
    logic [7:0]   m_mem [256];
    logic         m_written [256];
    logic [7:0]   d_mem [256];
    int           d_wait [N];

    always #5 clk = ~clk;

    data_mem_write_arbiter dut (
        .clk(clk),
        .reset(reset),
        .wr_req(wr_req),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .wr_ack(wr_ack),
        .mem_we(mem_we),
        .mem_waddr(mem_waddr),
        .mem_wdata(mem_wdata),
        .busy(busy)
`ifdef WR_ADDR_CONFLICT_EN
        ,
        .conflict(conflict),
        .conflict_sticky(conflict_sticky)
`endif
    );

    // Emulates the memory: commits the registered write on the following edge.
    always @(posedge clk) if (mem_we) d_mem[mem_waddr] <= mem_wdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ack = '0;
        m_we = 1'b0;
        m_addr = '0;
        m_data = '0;
        m_ptr = 0;
        m_conf = 1'b0;
        m_sticky = 1'b0;
        for (int i = 0; i < N; i++) d_wait[i] = 0;
    endtask

    task automatic set_port(input int i, input logic r, input logic [7:0] a, input logic [7:0] d);
        wr_req[i] = r;
        wr_addr[i*8 +: 8] = a;
        wr_data[i*8 +: 8] = d;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        wr_req = '0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic step();
        logic [N-1:0] elig;
        int g;
        #1;
        elig = wr_req & ~m_ack;
        check("busy", busy, 32'(|elig));
        if (m_we) begin
            m_mem[m_addr] = m_data;
            m_written[m_addr] = 1'b1;
        end
        g = -1;
        for (int k = 0; k < N; k++)
            if (g < 0 && elig[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        m_conf = 1'b0;
        for (int i = 0; i < N; i++)
            for (int j = i + 1; j < N; j++)
                if (elig[i] && elig[j] && wr_addr[i*8 +: 8] == wr_addr[j*8 +: 8]) m_conf = 1'b1;
        m_sticky = m_sticky | m_conf;
        for (int i = 0; i < N; i++) d_wait[i] = wr_req[i] ? d_wait[i] + 1 : 0;
        m_ack = '0;
        m_we = 1'b0;
        if (g >= 0) begin
            m_ack[g] = 1'b1;
            m_we = 1'b1;
            m_addr = wr_addr[g*8 +: 8];
            m_data = wr_data[g*8 +: 8];
            m_ptr = (g + 1) % N;
        end
        @(posedge clk);
        #1;
        check("mem_we", mem_we, m_we);
        check("wr_ack", wr_ack, m_ack);
        check("mem_waddr", mem_waddr, m_addr);
        check("mem_wdata", mem_wdata, m_data);
`ifdef WR_ADDR_CONFLICT_EN
        check("conflict", conflict, m_conf);
        check("conflict_sticky", conflict_sticky, m_sticky);
`endif
        for (int i = 0; i < N; i++)
            if (wr_ack[i]) begin
                check("fair_wait", 32'(d_wait[i] <= 2 * N), 1);
                d_wait[i] = 0;
            end
    endtask

    task automatic drive_rand();
        for (int i = 0; i < N; i++) begin
            if (wr_req[i] && m_ack[i]) begin
                if ($urandom_range(0, 1) == 0) set_port(i, 1'b0, wr_addr[i*8 +: 8], wr_data[i*8 +: 8]);
                else set_port(i, 1'b1, 8'($urandom_range(0, 15)), 8'($urandom));
            end else if (wr_req[i]) begin
                if ($urandom_range(0, 15) == 0) wr_req[i] = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                set_port(i, 1'b1, 8'($urandom_range(0, 15)), 8'($urandom));
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [N-1:0] seen;
        int dup;
        int diff;
        for (int a = 0; a < 256; a++) begin
            m_mem[a] = '0;
            m_written[a] = 1'b0;
        end
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_we", mem_we, 0);
        check("rst_ack", wr_ack, 0);
        check("rst_waddr", mem_waddr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_ptr", dut.r_rr_ptr, 0);
        check("rst_busy", busy, 0);
        @(negedge clk);
        reset = 1'b0;

        set_port(5, 1'b1, 8'h2A, 8'h7F);
        step();
        check("single_ack", wr_ack, 32'h0020);
        check("single_addr", mem_waddr, 32'h2A);
        check("single_data", mem_wdata, 32'h7F);
        check("single_ptr", dut.r_rr_ptr, 6);
        set_port(5, 1'b0, 8'h2A, 8'h7F);
        repeat (2) step();

        do_reset();
        for (int i = 0; i < N; i++) set_port(i, 1'b1, 8'(i), 8'(8'h40 + i));
        seen = '0;
        dup = 0;
        repeat (N) begin
            step();
            if ((seen & wr_ack) != 0) dup++;
            seen = seen | wr_ack;
            check("all_we", mem_we, 1);
        end
        check("all_seen", seen, 32'hFFFF);
        check("all_dup", dup, 0);
        repeat (N) begin
            step();
            check("all_we2", mem_we, 1);
        end
        wr_req = '0;
        repeat (2) step();

        do_reset();
        set_port(14, 1'b1, 8'h4E, 8'h14);
        step();
        check("wrap_ptr15", dut.r_rr_ptr, 15);
        set_port(14, 1'b0, 8'h4E, 8'h14);
        set_port(15, 1'b1, 8'h3F, 8'h15);
        set_port(0, 1'b1, 8'h30, 8'h10);
        step();
        check("wrap_first", wr_ack, 32'h8000);
        set_port(15, 1'b0, 8'h3F, 8'h15);
        step();
        check("wrap_second", wr_ack, 32'h0001);
        check("wrap_ptr1", dut.r_rr_ptr, 1);
        set_port(0, 1'b0, 8'h30, 8'h10);
        step();

        do_reset();
        set_port(4, 1'b1, 8'h44, 8'h04);
        step();
        set_port(4, 1'b0, 8'h44, 8'h04);
        set_port(9, 1'b1, 8'h99, 8'h09);
        set_port(3, 1'b1, 8'h33, 8'hC3);
        step();
        check("wd_win9", wr_ack, 32'h0200);
        set_port(3, 1'b0, 8'h33, 8'hC3);
        set_port(9, 1'b0, 8'h99, 8'h09);
        repeat (3) begin
            step();
            check("wd_ack3", wr_ack[3], 0);
            check("wd_nowrite", mem_we, 0);
        end

        do_reset();
        wr_req = '1;
        step();
        check("rg_we", mem_we, 1);
        #2;
        reset = 1'b1;
        #1;
        check("rg_we0", mem_we, 0);
        check("rg_ack0", wr_ack, 0);
        check("rg_ptr0", dut.r_rr_ptr, 0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        step();
        check("rg_port0", wr_ack, 32'h0001);
        wr_req = '0;
        repeat (2) step();

        do_reset();
        set_port(1, 1'b1, 8'h10, 8'hAA);
        set_port(8, 1'b1, 8'h10, 8'h55);
        step();
        check("same_first", wr_ack, 32'h0002);
`ifdef WR_ADDR_CONFLICT_EN
        check("conf_pulse", conflict, 1);
`endif
        set_port(1, 1'b0, 8'h10, 8'hAA);
        step();
        check("same_second", wr_ack, 32'h0100);
`ifdef WR_ADDR_CONFLICT_EN
        check("conf_drop", conflict, 0);
        check("conf_sticky", conflict_sticky, 1);
`endif
        set_port(8, 1'b0, 8'h10, 8'h55);
        repeat (2) step();
        check("same_mem", d_mem[8'h10], 32'h55);

        do_reset();
        repeat (3000) begin
            drive_rand();
            step();
        end
        wr_req = '0;
        repeat (2) step();
        diff = 0;
        for (int a = 0; a < 256; a++)
            if (m_written[a] && d_mem[a] !== m_mem[a]) diff++;
        check("mem_contents", diff, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
